fc_argmax: RTL and testbench

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc_argmax.sv | 118 +++++++++++
 tb/tb_fc_argmax.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fc_pkg
//  Purpose : Shared definitions for the fully-connected argmax block:
//            default word geometry, the fixed-point word type and the
//            controller state encoding.
//  Rev     : 1.0  initial release
// ============================================================================
package fc_pkg;

    localparam int FC_WORD_SIZE   = 16;   // bits per fixed-point word
    localparam int FC_INT_SLICE   = 8;    // integer bits per word (Q8.8)
    localparam int FC_NUM_CLASSES = 10;   // default classifier width

    // Signed fixed-point word at the default geometry
    typedef logic signed [FC_WORD_SIZE-1:0] fx_word_t;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fc_state_e;

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_argmax.sv
`default_nettype none
// ============================================================================
//  Module  : fc_argmax
//  Purpose : Captures a vector of signed fixed-point scores and returns the
//            index and value of the largest element, scanning one element
//            per cycle. Ties resolve to the lowest index.
//  Ports   : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - input vector handshake, in_vec payload
//            out_valid/out_ready - result handshake
//            out_class/out_max - result index / value (qualified by out_valid)
//            busy              - high while scanning or holding a result
//  Rev     : 1.0  initial release
// ============================================================================
module fc_argmax
    import fc_pkg::*;
#(
    parameter int WORD_SIZE   = FC_WORD_SIZE,
    parameter int INT_SLICE   = FC_INT_SLICE,
    parameter int NUM_CLASSES = FC_NUM_CLASSES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_SIZE-1:0]           in_vec [NUM_CLASSES-1:0],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0] out_class,
    output logic [WORD_SIZE-1:0]           out_max,
    output logic                           busy
);

    localparam int CW = $clog2(NUM_CLASSES);
    localparam logic [CW-1:0] c_last = CW'(NUM_CLASSES - 1);

    // Reject geometries the block cannot represent
    if (NUM_CLASSES < 2 || INT_SLICE < 1 || INT_SLICE > WORD_SIZE) begin : g_param_check
        $error("fc_argmax: illegal parameter set");
    end

    fc_state_e             r_state;
    logic [WORD_SIZE-1:0]  r_buf [NUM_CLASSES-1:0];
    logic [WORD_SIZE-1:0]  r_run_max;
    logic [CW-1:0]         r_run_idx;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_out_class;
    logic [WORD_SIZE-1:0]  r_out_max;

    logic [WORD_SIZE-1:0]  w_cand;
    logic                  w_gt;
    logic [WORD_SIZE-1:0]  w_next_max;
    logic [CW-1:0]         w_next_idx;

    // Strictly-greater signed compare keeps the earlier index on ties
    always_comb begin
        w_cand     = r_buf[r_cnt];
        w_gt       = $signed(w_cand) > $signed(r_run_max);
        w_next_max = w_gt ? w_cand : r_run_max;
        w_next_idx = w_gt ? r_cnt  : r_run_idx;
    end

    // Vector buffer: only loaded on an accepted input, so later changes on
    // in_vec are invisible to the scan in progress
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            r_buf <= in_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_cnt       <= '0;
            r_out_class <= '0;
            r_out_max   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_run_max <= in_vec[0];
                        r_run_idx <= '0;
                        r_cnt     <= CW'(1);
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    r_run_max <= w_next_max;
                    r_run_idx <= w_next_idx;
                    if (r_cnt == c_last) begin
                        // Final compare lands directly in the result registers
                        r_out_max   <= w_next_max;
                        r_out_class <= w_next_idx;
                        r_cnt       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_class = r_out_class;
    assign out_max   = r_out_max;

endmodule : fc_argmax
`default_nettype wire

// File: tb/tb_fc_argmax.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fc_argmax
//  Purpose : Self-checking bench for fc_argmax: directed vectors plus
//            randomized vectors compared against a behavioural argmax model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fc_argmax;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int CW = $clog2(N);
    localparam int LIMIT = 40;

    typedef logic [W-1:0] vec_t [N-1:0];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    vec_t          in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_class;
    logic [W-1:0]  out_max;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    fc_argmax #(.WORD_SIZE(W), .INT_SLICE(8), .NUM_CLASSES(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_max   (out_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: find the largest signed value, then its first occurrence
    function automatic void model(input vec_t v, output logic [CW-1:0] cls,
                                  output logic [W-1:0] mx);
        int m;
        m = $signed(v[0]);
        for (int k = 1; k < N; k++)
            if ($signed(v[k]) > m) m = $signed(v[k]);
        mx  = m[W-1:0];
        cls = '0;
        for (int k = N - 1; k >= 0; k--)
            if (v[k] == mx) cls = CW'(k);
    endfunction

    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            for (int k = 0; k < N; k++) in_vec[k] = W'($urandom);
            tick();
            lat++;
        end
        if (!out_valid) chk({tag, ":timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input vec_t v, input int stall, input string tag);
        int            lat;
        logic [CW-1:0] e_cls;
        logic [W-1:0]  e_max;
        model(v, e_cls, e_max);
        out_ready = (stall == 0);
        in_vec    = v;
        in_valid  = 1'b1;
        chk({tag, ":in_ready_pre"}, 32'(in_ready), 32'd1);
        tick();                                   // capture edge
        in_valid = 1'b0;
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        wait_result(tag, lat);
        chk({tag, ":latency"}, 32'(lat), 32'(N - 1));
        chk({tag, ":class"}, 32'(out_class), 32'(e_cls));
        chk({tag, ":max"},   32'(out_max),   32'(e_max));
        for (int s = 0; s < stall; s++) begin
            chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_class"}, 32'(out_class), 32'(e_cls));
            chk({tag, ":hold_max"},   32'(out_max),   32'(e_max));
            chk({tag, ":hold_inrdy"}, 32'(in_ready),  32'd0);
            if (s == 1) begin
                for (int k = 0; k < N; k++) in_vec[k] = W'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, ":valid_at_hs"}, 32'(out_valid), 32'd1);
        tick();                                   // handshake edge
        chk({tag, ":post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":post_inrdy"}, 32'(in_ready),  32'd1);
        chk({tag, ":post_class"}, 32'(out_class), 32'(e_cls));
        chk({tag, ":post_max"},   32'(out_max),   32'(e_max));
    endtask

    initial begin
        vec_t          v, v2;
        logic [CW-1:0] c1, c2;
        logic [W-1:0]  m1, m2;
        int            lat;
        logic          seen;
        logic [W-1:0]  edge_vals [4];

        edge_vals[0] = 16'h8000;
        edge_vals[1] = 16'hFFFF;
        edge_vals[2] = 16'h0000;
        edge_vals[3] = 16'h7FFF;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < N; k++) in_vec[k] = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:out_class", 32'(out_class), 32'd0);
        chk("reset:out_max",   32'(out_max),   32'd0);
        chk("reset:busy",      32'(busy),      32'd0);
        chk("reset:in_ready",  32'(in_ready),  32'd1);

        // Basic argmax
        v[0] = 16'h0100; v[1] = 16'h0280; v[2] = 16'hFF00; v[3] = 16'h0050;
        v[4] = 16'h0000; v[5] = 16'h0300; v[6] = 16'h0010; v[7] = 16'h0020;
        v[8] = 16'h0030; v[9] = 16'h0040;
        send(v, 0, "basic");
        chk("basic:const_class", 32'(out_class), 32'd5);
        chk("basic:const_max",   32'(out_max),   32'h0300);

        // Backpressure on the same vector
        send(v, 5, "bp");

        // All negative: signed compare must pick the last element
        for (int k = 0; k < N; k++) v[k] = 16'h8000 + W'(k);
        send(v, 0, "neg");
        chk("neg:const_class", 32'(out_class), 32'd9);
        chk("neg:const_max",   32'(out_max),   32'h8009);

        // Ties
        for (int k = 0; k < N; k++) v[k] = 16'h0200;
        v[3] = 16'h0400; v[7] = 16'h0400;
        send(v, 0, "tie");
        chk("tie:const_class", 32'(out_class), 32'd3);
        chk("tie:const_max",   32'(out_max),   32'h0400);

        // Reset four cycles after capture
        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        out_ready = 1'b1;
        in_vec = v; in_valid = 1'b1;
        tick();                                   // capture
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();                                   // fourth edge after capture
        rst = 1'b0;
        chk("rst_mid:out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid:out_class", 32'(out_class), 32'd0);
        chk("rst_mid:out_max",   32'(out_max),   32'd0);
        chk("rst_mid:in_ready",  32'(in_ready),  32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("rst_mid:no_stale", 32'(seen), 32'd0);

        // Back-to-back with in_valid held high
        for (int k = 0; k < N; k++) begin
            v[k]  = W'($urandom);
            v2[k] = W'($urandom);
        end
        model(v, c1, m1);
        model(v2, c2, m2);
        out_ready = 1'b1;
        in_vec = v; in_valid = 1'b1;
        tick();                                   // first capture
        in_vec = v2;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin tick(); lat++; end
        chk("b2b:lat1",   32'(lat),       32'(N - 1));
        chk("b2b:class1", 32'(out_class), 32'(c1));
        chk("b2b:max1",   32'(out_max),   32'(m1));
        tick();                                   // first handshake
        chk("b2b:idle_gap", 32'(in_ready), 32'd1);
        tick();                                   // second capture
        in_valid = 1'b0;
        chk("b2b:cap2", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < LIMIT) begin tick(); lat++; end
        chk("b2b:lat2",   32'(lat),       32'(N - 1));
        chk("b2b:class2", 32'(out_class), 32'(c2));
        chk("b2b:max2",   32'(out_max),   32'(m2));
        tick();

        // Randomized vectors, half drawn from boundary values to force ties
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++)
                v[k] = (t % 2 == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
            send(v, int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fc_argmax
`default_nettype wire
